// File: rtl/i2s_rx.sv
// i2s_rx: I2S microphone receiver producing 16-bit left/right sample pairs with a valid/ready handshake.
// Optional sticky overrun flag is built only when I2S_RX_OVERRUN_EN is defined.
`timescale 1ns/1ps
module i2s_rx #(
    parameter bit WS_POL = 1'b0
) (
    input  logic        clk_48mhz,
    input  logic        reset_n,
    input  logic        bclk_in,
    input  logic        sd_in,
    input  logic        sample_ready,
    output logic        ws_out,
    output logic [15:0] left_data,
    output logic [15:0] right_data,
    output logic        sample_valid,
    output logic        overrun
);
    logic        bclk_q;
    logic [1:0]  sd_sync_q;
    logic [4:0]  slot_q, slot_d;
    logic        ws_q, ws_d;
    logic [15:0] left_sr_q, left_sr_d, right_sr_q, right_sr_d;
    logic [15:0] left_q, left_d, right_q, right_d;
    logic        valid_q, valid_d, primed_q, primed_d;
    logic        rise, fall, sd_s, left_slot, frame_done;

    assign rise      = bclk_in & ~bclk_q;
    assign fall      = ~bclk_in & bclk_q;
    assign sd_s      = sd_sync_q[1];
    assign left_slot = (slot_q != 5'd0) && (slot_q <= 5'd16);
    assign frame_done = rise && (slot_q == 5'd0) && primed_q;

    // Next-state: slot/ws advance on bclk falls, data shifts on rises, frame completes at slot-0 rise.
    always_comb begin
        slot_d     = fall ? slot_q + 5'd1 : slot_q;
        ws_d       = fall ? (slot_d[4] ? ~WS_POL : WS_POL) : ws_q;
        left_sr_d  = (rise && left_slot) ? {left_sr_q[14:0], sd_s} : left_sr_q;
        right_sr_d = (rise && !left_slot) ? {right_sr_q[14:0], sd_s} : right_sr_q;
        primed_d   = primed_q | (rise && (slot_q == 5'd16));
        left_d     = frame_done ? left_sr_q : left_q;
        right_d    = frame_done ? {right_sr_q[14:0], sd_s} : right_q;
        valid_d    = frame_done | (valid_q & ~sample_ready);
    end

    // State registers; the sd pad is double-synchronized, bclk is already in this domain.
    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            bclk_q     <= 1'b0;
            sd_sync_q  <= 2'b00;
            slot_q     <= 5'd0;
            ws_q       <= WS_POL;
            left_sr_q  <= 16'd0;
            right_sr_q <= 16'd0;
            left_q     <= 16'd0;
            right_q    <= 16'd0;
            valid_q    <= 1'b0;
            primed_q   <= 1'b0;
        end else begin
            bclk_q     <= bclk_in;
            sd_sync_q  <= {sd_sync_q[0], sd_in};
            slot_q     <= slot_d;
            ws_q       <= ws_d;
            left_sr_q  <= left_sr_d;
            right_sr_q <= right_sr_d;
            left_q     <= left_d;
            right_q    <= right_d;
            valid_q    <= valid_d;
            primed_q   <= primed_d;
        end
    end

`ifdef I2S_RX_OVERRUN_EN
    logic ovr_q, ovr_d;
    assign ovr_d = ovr_q | (frame_done & valid_q & ~sample_ready);

    // Sticky overrun: a held pair was overwritten before the consumer took it.
    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) ovr_q <= 1'b0;
        else          ovr_q <= ovr_d;
    end

    assign overrun = ovr_q;
`else
    assign overrun = 1'b0;
`endif

    assign ws_out       = ws_q;
    assign left_data    = left_q;
    assign right_data   = right_q;
    assign sample_valid = valid_q;
endmodule
